coin_change_fsm: RTL

- Parametrised successor to the hard-coded payment/change schematic.
- Accumulates coin values into a credit register, then, on a pay request, charges a configurable price.
- Pays back the change as a sequence of high- and low-denomination coin requests to a hopper, under a request/acknowledge handshake.
- Also supports cancel/refund. Sits between the coin acceptor and the coin hopper, next to the bar-code price path.

---
 rtl/coin_change_fsm.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/coin_change_fsm.sv
// Coin accumulator and change dispenser: credits coins, charges PRICE on pg, pays change via dez/dois hopper handshake.
// Optional completed-sale counter enabled by defining COIN_CHANGE_TXN_COUNT_EN.
module coin_change_fsm #(
  parameter int VALUE_W = 8,
  parameter int PRICE   = 30,
  parameter int COIN_HI = 10,
  parameter int COIN_LO = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               coin_valid,
  input  logic [VALUE_W-1:0] coin_in,
  input  logic               pg,
  input  logic               cancel,
  input  logic               hopper_ack,
  output logic               dez,
  output logic               dois,
  output logic               fim,
  output logic               insufficient,
  output logic               coin_reject,
  output logic               overflow,
  output logic [VALUE_W-1:0] residue,
  output logic [VALUE_W-1:0] credit,
  output logic               busy,
  output logic [15:0]        txn_count
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPENSE = 2'd1;
  localparam logic [1:0] ST_DONE     = 2'd2;

  localparam logic [VALUE_W-1:0] PRICE_V = VALUE_W'(PRICE);
  localparam logic [VALUE_W-1:0] HI_V    = VALUE_W'(COIN_HI);
  localparam logic [VALUE_W-1:0] LO_V    = VALUE_W'(COIN_LO);

  logic [1:0]         state;
  logic [VALUE_W-1:0] change;
  logic               is_sale;

  logic [VALUE_W:0]   sum;
  logic [VALUE_W-1:0] start_change;
  logic               pay_ok;
  logic               start_txn;

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    sum          = {1'b0, credit} + {1'b0, coin_in};
    pay_ok       = (credit >= PRICE_V);
    start_change = credit;
    if (!cancel) start_change = credit - PRICE_V;
    start_txn    = !coin_valid && (cancel || (pg && pay_ok));
  end

  // NOTE: sequential state uses non-blocking assignments; pulse outputs default low each cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      change       <= '0;
      is_sale      <= 1'b0;
      credit       <= '0;
      residue      <= '0;
      overflow     <= 1'b0;
      dez          <= 1'b0;
      dois         <= 1'b0;
      fim          <= 1'b0;
      insufficient <= 1'b0;
      coin_reject  <= 1'b0;
      busy         <= 1'b0;
    end else begin
      fim          <= 1'b0;
      insufficient <= 1'b0;
      coin_reject  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (coin_valid) begin
            if (coin_in != '0) begin
              if (sum[VALUE_W]) begin
                credit   <= '1;
                overflow <= 1'b1;
              end else begin
                credit <= sum[VALUE_W-1:0];
              end
            end
          end else if (start_txn) begin
            // First coin request is issued on entry so busy and dez/dois rise together.
            change  <= start_change;
            credit  <= '0;
            is_sale <= !cancel;
            state   <= ST_DISPENSE;
            busy    <= 1'b1;
            dez     <= (start_change >= HI_V);
            dois    <= (start_change < HI_V) && (start_change >= LO_V);
          end else if (pg) begin
            insufficient <= 1'b1;
          end
        end
        ST_DISPENSE: begin
          if (coin_valid) coin_reject <= 1'b1;
          if (dez || dois) begin
            if (hopper_ack) begin
              change <= change - (dez ? HI_V : LO_V);
              dez    <= 1'b0;
              dois   <= 1'b0;
            end
          end else if (change >= HI_V) begin
            dez <= 1'b1;
          end else if (change >= LO_V) begin
            dois <= 1'b1;
          end else begin
            residue <= change;
            fim     <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (coin_valid) coin_reject <= 1'b1;
          overflow <= 1'b0;
          busy     <= 1'b0;
          is_sale  <= 1'b0;
          state    <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          dez   <= 1'b0;
          dois  <= 1'b0;
        end
      endcase
    end
  end

`ifdef COIN_CHANGE_TXN_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      txn_count <= 16'd0;
    end else if ((state == ST_DONE) && is_sale) begin
      txn_count <= txn_count + 16'd1;
    end
  end
`else
  assign txn_count = 16'd0;
`endif

endmodule
